// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage and IF/ID register: one-outstanding imem fetch, stall hold buffer, branch redirect with kill.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              id_stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} stateT;

  stateT               state, stateNext;
  logic [ADDR_W-1:0]   pc, pcNext;
  logic [ADDR_W-1:0]   pendingPc, pendingPcNext;
  logic                kill, killNext;
  logic                holdValid, holdValidNext;
  logic [INSTR_W-1:0]  holdInstr, holdInstrNext;
  logic [ADDR_W-1:0]   holdPc4, holdPc4Next;
  logic                validNext;
  logic [INSTR_W-1:0]  instrNext;
  logic [ADDR_W-1:0]   pc4Next;
  logic                reqNext;
  logic                slotFree;
  logic [ADDR_W-1:0]   respPc4;

  // The fetch address is the PC register itself.
  assign imem_addr = pc;

  // Next-state and datapath update; a redirect overrides everything else.
  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    pendingPcNext = pendingPc;
    killNext      = kill;
    holdValidNext = holdValid;
    holdInstrNext = holdInstr;
    holdPc4Next   = holdPc4;
    validNext     = if_valid;
    instrNext     = if_instr;
    pc4Next       = if_pc_plus4;
    slotFree      = !if_valid || !id_stall;
    respPc4       = pendingPc + ADDR_W'(4);

    if (if_valid && !id_stall) validNext = 1'b0;

    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        if (imem_gnt) begin
          stateNext     = WAIT;
          pendingPcNext = pc;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill) begin
            killNext  = 1'b0;
            stateNext = REQ;
          end else if (slotFree) begin
            validNext = 1'b1;
            instrNext = imem_rdata;
            pc4Next   = respPc4;
            pcNext    = respPc4;
            stateNext = REQ;
          end else begin
            holdValidNext = 1'b1;
            holdInstrNext = imem_rdata;
            holdPc4Next   = respPc4;
            pcNext        = respPc4;
            stateNext     = HOLD;
          end
        end
      end
      HOLD: begin
        if (!id_stall) begin
          if (holdValid) begin
            validNext = 1'b1;
            instrNext = holdInstr;
            pc4Next   = holdPc4;
          end
          holdValidNext = 1'b0;
          stateNext     = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (br_taken) begin
      pcNext        = {br_target[ADDR_W-1:2], 2'b00};
      validNext     = 1'b0;
      holdValidNext = 1'b0;
      case (state)
        WAIT: begin
          stateNext = imem_rvalid ? REQ : WAIT;
          killNext  = !imem_rvalid;
        end
        REQ: begin
          stateNext = imem_gnt ? WAIT : REQ;
          killNext  = imem_gnt;
        end
        default: begin
          stateNext = REQ;
          killNext  = 1'b0;
        end
      endcase
    end

    reqNext = (stateNext == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pendingPc   <= '0;
      kill        <= 1'b0;
      holdValid   <= 1'b0;
      holdInstr   <= '0;
      holdPc4     <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
      imem_req    <= 1'b0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      pendingPc   <= pendingPcNext;
      kill        <= killNext;
      holdValid   <= holdValidNext;
      holdInstr   <= holdInstrNext;
      holdPc4     <= holdPc4Next;
      if_valid    <= validNext;
      if_instr    <= instrNext;
      if_pc_plus4 <= pc4Next;
      imem_req    <= reqNext;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Accepted-instruction and empty-slot counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (if_valid && !id_stall) perf_fetched <= perf_fetched + 32'd1;
      if (!if_valid)             perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus hand-written reset-during-fetch sequence.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;

  logic        rstHi_n;
  logic        hiReq;
  logic [31:0] hiAddr;
  logic        hiGnt;
  logic        hiRvalid;
  logic [31:0] hiRdata;
  logic        hiStall;
  logic        hiBr;
  logic [31:0] hiTgt;
  logic        hiValid;
  logic [31:0] hiInstr;
  logic [31:0] hiPc4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf0, pb0, pfHi, pbHi;
`endif

  int nCmp = 0;
  int nErr = 0;
  int pendCnt = 0;
  logic [31:0] pendAddr = '0;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .br_taken(br_taken), .br_target(br_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(pf0), .perf_bubbles(pb0)
`endif
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dutHi (
    .clk(clk), .rst_n(rstHi_n),
    .imem_req(hiReq), .imem_addr(hiAddr), .imem_gnt(hiGnt),
    .imem_rvalid(hiRvalid), .imem_rdata(hiRdata),
    .id_stall(hiStall), .br_taken(hiBr), .br_target(hiTgt),
    .if_valid(hiValid), .if_instr(hiInstr), .if_pc_plus4(hiPc4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(pfHi), .perf_bubbles(pbHi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        gnt;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    int          lat;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePc4;
    logic [31:0] eInstr;
  } vecT;

  vecT vecs[22];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h8) ? 32'h8C22_0004 : (32'hA500_0000 | {8'h00, a[23:0]});
  endfunction

  function automatic vecT mk(input logic g, input logic s, input logic b, input logic [31:0] t,
                             input int l, input logic rq, input logic [31:0] ad,
                             input logic v, input logic [31:0] p4, input logic [31:0] ins);
    vecT r;
    r.gnt = g; r.stall = s; r.br = b; r.tgt = t; r.lat = l;
    r.eReq = rq; r.eAddr = ad; r.eValid = v; r.ePc4 = p4; r.eInstr = ins;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; memory models answer granted requests after lat cycles (dutHi: always 1).
  task automatic cycle(input int lat);
    logic        hs, hsHi;
    logic [31:0] a, aHi;
    hs  = imem_req & imem_gnt;
    a   = imem_addr;
    hsHi = hiReq & hiGnt;
    aHi  = hiAddr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    hiRvalid    = hsHi;
    hiRdata     = memWord(aHi);
    if (hs) begin
      pendCnt  = lat;
      pendAddr = a;
    end
    if (pendCnt > 0) begin
      pendCnt--;
      if (pendCnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(pendAddr);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rstHi_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_stall = 1'b0; br_taken = 1'b0; br_target = '0;
    hiGnt = 1'b1; hiRvalid = 1'b0; hiRdata = '0;
    hiStall = 1'b0; hiBr = 1'b0; hiTgt = '0;

    //        gnt  stl  br   tgt           lat req  addr          vld  pc4           instr
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h4,   1'b1, 32'h4,   memWord(32'h0));
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h4,   1'b0, 32'h0,   32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h8,   1'b1, 32'h8,   memWord(32'h4));
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1, 1'b0, 32'h8,   1'b1, 32'h8,   memWord(32'h4));
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1, 1'b0, 32'hC,   1'b1, 32'h8,   memWord(32'h4));
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1, 1'b0, 32'hC,   1'b1, 32'h8,   memWord(32'h4));
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1, 1'b0, 32'hC,   1'b1, 32'h8,   memWord(32'h4));
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1, 1'b0, 32'hC,   1'b1, 32'h8,   memWord(32'h4));
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'hC,   1'b1, 32'hC,   32'h8C22_0004);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,   2, 1'b0, 32'hC,   1'b0, 32'h0,   32'h0);
    vecs[12] = mk(1'b1, 1'b0, 1'b1, 32'h43,  2, 1'b0, 32'h40,  1'b0, 32'h0,   32'h0);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h40,  1'b0, 32'h0,   32'h0);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h40,  1'b0, 32'h0,   32'h0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h44,  1'b1, 32'h44,  memWord(32'h40));
    vecs[16] = mk(1'b1, 1'b0, 1'b1, 32'h100, 1, 1'b0, 32'h100, 1'b0, 32'h0,   32'h0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0);
    vecs[19] = mk(1'b0, 1'b0, 1'b1, 32'h203, 1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h200, 1'b0, 32'h0,   32'h0);
    vecs[21] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h204, 1'b1, 32'h204, memWord(32'h200));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr,         32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr,          32'h0);
    chk("rst_pc4",   if_pc_plus4,       32'h0);
    chk("rst_hiAddr", hiAddr,           32'hFFFF_FFFC);

    rst_n = 1'b1; rstHi_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      imem_gnt  = vecs[i].gnt;
      id_stall  = vecs[i].stall;
      br_taken  = vecs[i].br;
      br_target = vecs[i].tgt;
      cycle(vecs[i].lat);
      chk($sformatf("v%0d_req", i),   {31'h0, imem_req}, {31'h0, vecs[i].eReq});
      chk($sformatf("v%0d_addr", i),  imem_addr,         vecs[i].eAddr);
      chk($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].eValid});
      if (vecs[i].eValid) begin
        chk($sformatf("v%0d_pc4", i),   if_pc_plus4, vecs[i].ePc4);
        chk($sformatf("v%0d_instr", i), if_instr,    vecs[i].eInstr);
      end
      if (i == 0) chk("hi_addr0", hiAddr, 32'hFFFF_FFFC);
      if (i == 2) begin
        chk("hi_valid", {31'h0, hiValid}, 32'h1);
        chk("hi_pc4",   hiPc4,            32'h0);
        chk("hi_instr", hiInstr,          memWord(32'hFFFF_FFFC));
        chk("hi_addr1", hiAddr,           32'h0);
        chk("hi_req1",  {31'h0, hiReq},   32'h1);
      end
    end
    br_taken = 1'b0;

    // Reset while a slow fetch is outstanding; its late response must be ignored.
    imem_gnt = 1'b1; id_stall = 1'b1;
    cycle(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   {31'h0, imem_req}, 32'h0);
    chk("mid_rst_addr",  imem_addr,         32'h0);
    chk("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("mid_rst_pc4",   if_pc_plus4,       32'h0);
    imem_gnt = 1'b0; id_stall = 1'b0;
    cycle(1);
    rst_n = 1'b1;
    cycle(1);
    chk("post_rst_rvalid_seen", {31'h0, imem_rvalid}, 32'h1);
    chk("post_rst_req",  {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr,         32'h0);
    cycle(1);
    chk("post_rst_req2",   {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr2",  imem_addr,         32'h0);
    chk("post_rst_valid2", {31'h0, if_valid}, 32'h0);
    imem_gnt = 1'b1;
    cycle(1);
    chk("post_rst_wait_valid", {31'h0, if_valid}, 32'h0);
    cycle(1);
    chk("post_rst_valid", {31'h0, if_valid}, 32'h1);
    chk("post_rst_pc4",   if_pc_plus4,       32'h4);
    chk("post_rst_instr", if_instr,          memWord(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the MIPS datapath, directly upstream of decode/control. Holds the PC and issues word fetches to instruction memory over a request/grant plus response handshake, allowing one outstanding request. Delivers instruction and PC+4 to decode with stall support. Branch redirects flush in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value fetched first after reset; bits [1:0] must be 0
ADDR_W, 32, PC/address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  word address of request (byte address, [1:0]=0)
imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt = handshake)
imem_rvalid  in  1  response valid; exactly one per granted request, ≥1 cycle after grant
imem_rdata  in  32  instruction word
id_stall  in  1  decode cannot accept; hold if_* outputs
br_taken  in  1  redirect pulse (resolved BEQ)
br_target  in  ADDR_W  redirect address; [1:0] forced to 0 internally
if_valid  out  1  if_instr/if_pc_plus4 hold a live instruction
if_instr  out  32  instruction to decode (Opcode = [31:26])
if_pc_plus4  out  ADDR_W  address of if_instr + 4

Behaviour:
- Reset (rst_n low, async): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc_plus4=0, hold buffer empty, kill=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req=1, imem_addr=pc. On gnt -> WAIT, latch pending_pc=pc. No gnt -> stay; imem_addr stable.
- WAIT: imem_req=0. On rvalid:
  - kill=1: drop data, clear kill, -> REQ (pc already holds target).
  - Output slot free (if_valid=0 or id_stall=0): load if_instr=rdata, if_pc_plus4=pending_pc+4, if_valid=1; pc=pending_pc+4; -> REQ.
  - Output slot busy (if_valid=1 and id_stall=1): write hold buffer; pc=pending_pc+4; -> HOLD.
- HOLD: imem_req=0. When id_stall=0: hold buffer moves to output, buffer empties, -> REQ.
- Decode consumes an instruction on any cycle with if_valid=1 and id_stall=0. If nothing refills the slot that cycle, if_valid=0 next cycle.
- Best-case latency: grant cycle N, rvalid cycle N+1, if_valid at N+2. Throughput: one instruction per 2 cycles at zero memory wait.
- Redirect (br_taken=1) has priority over stall and all other events, at the same edge:
  - pc=br_target&~3; if_valid=0; hold buffer cleared.
  - State WAIT -> stay WAIT, kill=1 (unless rvalid arrives the same cycle: drop it, -> REQ).
  - State REQ with gnt the same cycle -> WAIT with kill=1.
  - State REQ without gnt -> stay REQ, address changes next cycle.
  - State HOLD or IDLE -> REQ.
- Arithmetic: PC+4 modulo 2^ADDR_W; 32'hFFFF_FFFC+4 = 0.
- imem_rvalid outside WAIT is ignored (protocol violation).
- Reset mid-operation: all state returns to reset values immediately. A response arriving after reset release for a pre-reset request is ignored, because state is IDLE/REQ.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_fetched[31:0] and perf_bubbles[31:0]. Both reset to 0 and wrap at 2^32.
- perf_fetched increments per instruction accepted by decode (if_valid & ~id_stall).
- perf_bubbles increments per cycle with if_valid=0 and rst_n high.
When undefined, neither port nor counter logic exists.

Test Plan:
- Reset release, RESET_PC=0, gnt tied 1, rvalid one cycle after grant, id_stall=0 -> imem_addr sequence 0,4,8. First if_valid at cycle 3 after release, with if_pc_plus4=4.
- id_stall=1 held 5 cycles while fetch for addr 8 returns 32'h8C220004 -> HOLD entered, no imem_req. After stall drops, if_instr=32'h8C220004 and if_pc_plus4=12 the next cycle, then imem_addr=12.
- br_taken with br_target=32'h0000_0043 while in WAIT -> stale response dropped. Next request addr=32'h0000_0040, and the first delivered if_pc_plus4=32'h44.
- br_taken together with gnt in REQ -> that response is killed. Request to the target issued the cycle after the response arrives.
- RESET_PC=32'hFFFF_FFFC -> second request address 0, if_pc_plus4 of first instruction = 0.
- rst_n asserted in WAIT, then rvalid pulses after release -> response ignored, imem_addr=RESET_PC, if_valid stays 0 until a fresh fetch completes.
